fifo_drain_ctrl: RTL and testbench

// - Read-side sequencer for the FIFO: pops words and hands them one at a time to a byte-serial transmitter (UART TX style).
// - Drains in bursts once the FIFO level exceeds the almost-empty threshold.
// - Forces a flush after FLUSH_CYCLES of a non-empty but almost-empty FIFO.
// - Also drives the FIFO AE_level configuration.

---
 rtl/fifo_drain_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain sequencer: pops FIFO words one at a time into a byte-serial TX, bursting above AE or flushing stale residue.
// Pop-to-TX-start is 3 cycles nominal; stalls in LOAD while tx_active_i is high and never holds more than one word in flight.
module fifo_drain_ctrl #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int AE_LEVEL     = 1,
  parameter int FLUSH_CYCLES = 1000,
  parameter int GAP_CYCLES   = 0,
  parameter int DV_TIMEOUT   = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic                     fifo_empty_i,
  input  logic                     fifo_AE_i,
  output logic                     fifo_rd_en_o,
  input  logic                     fifo_rd_dv_i,
  input  logic [WIDTH-1:0]         fifo_rd_data_i,
  output logic [$clog2(DEPTH)-1:0] AE_level_o,
  output logic                     tx_dv_o,
  output logic [WIDTH-1:0]         tx_byte_o,
  input  logic                     tx_active_i,
  input  logic                     tx_done_i,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [15:0]              words_sent_o
);

  localparam int LW       = $clog2(DEPTH);
  localparam int FW       = $clog2(FLUSH_CYCLES + 1);
  localparam int TW       = $clog2(DV_TIMEOUT);
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {IDLE, POP, WAIT_DV, LOAD, WAIT_TX, GAP} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             burst_q, burst_d;
  logic             err_q, err_d;
  logic             tx_dv_q, tx_dv_d;
  logic [WIDTH-1:0] byte_q, byte_d;
  logic [15:0]      words_q, words_d;
  logic             start;
  logic             more;

  assign start = enable_i && !fifo_empty_i &&
                 (!fifo_AE_i || (flush_q == FW'(FLUSH_CYCLES)) || burst_q);
  assign more  = enable_i && !fifo_empty_i;

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    burst_d = burst_q;
    err_d   = err_q;
    tx_dv_d = 1'b0;
    byte_d  = byte_q;
    words_d = words_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = POP;
          burst_d = 1'b1;
          flush_d = '0;
        end else if (fifo_empty_i) begin
          flush_d = '0;
        end else if (fifo_AE_i && (flush_q != FW'(FLUSH_CYCLES))) begin
          flush_d = flush_q + 1'b1;
        end
      end
      POP: begin
        state_d = WAIT_DV;
        tmo_d   = '0;
      end
      WAIT_DV: begin
        if (fifo_rd_dv_i) begin
          byte_d  = fifo_rd_data_i;
          state_d = LOAD;
        end else if (tmo_q == TW'(DV_TIMEOUT - 1)) begin
          // The popped word is lost; report it and fall back rather than hang
          err_d   = 1'b1;
          burst_d = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      LOAD: begin
        if (!tx_active_i) begin
          tx_dv_d = 1'b1;
          state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (tx_done_i) begin
          words_d = words_q + 16'd1;
          if (GAP_CYCLES > 0) begin
            gap_d   = '0;
            state_d = GAP;
          end else if (more) begin
            state_d = POP;
          end else begin
            burst_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          if (more) begin
            state_d = POP;
          end else begin
            burst_d = 1'b0;
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      flush_q <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      burst_q <= 1'b0;
      err_q   <= 1'b0;
      tx_dv_q <= 1'b0;
      byte_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      tx_dv_q <= tx_dv_d;
      byte_q  <= byte_d;
      words_q <= words_d;
    end
  end

  assign fifo_rd_en_o = (state_q == POP);
  assign AE_level_o   = LW'(AE_LEVEL);
  assign tx_dv_o      = tx_dv_q;
  assign tx_byte_o    = byte_q;
  assign busy_o       = (state_q != IDLE);
  assign err_o        = err_q;
  assign words_sent_o = words_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: queue-based FIFO and byte-serial TX models around the DUT, directed scenarios then random traffic.
module tb_fifo_drain_ctrl;

  localparam int AE_LVL = 1;
  localparam int FLUSH  = 20;
  localparam int DVTO   = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        enable_i;
  logic        fifo_empty_i   = 1'b1;
  logic        fifo_AE_i      = 1'b1;
  logic        fifo_rd_en_o;
  logic        fifo_rd_dv_i   = 1'b0;
  logic [7:0]  fifo_rd_data_i = 8'h00;
  logic [1:0]  AE_level_o;
  logic        tx_dv_o;
  logic [7:0]  tx_byte_o;
  logic        tx_active_i    = 1'b0;
  logic        tx_done_i      = 1'b0;
  logic        busy_o;
  logic        err_o;
  logic [15:0] words_sent_o;

  fifo_drain_ctrl #(
    .WIDTH(8), .DEPTH(4), .AE_LEVEL(AE_LVL), .FLUSH_CYCLES(FLUSH),
    .GAP_CYCLES(2), .DV_TIMEOUT(DVTO)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i),
    .fifo_empty_i(fifo_empty_i), .fifo_AE_i(fifo_AE_i),
    .fifo_rd_en_o(fifo_rd_en_o), .fifo_rd_dv_i(fifo_rd_dv_i),
    .fifo_rd_data_i(fifo_rd_data_i), .AE_level_o(AE_level_o),
    .tx_dv_o(tx_dv_o), .tx_byte_o(tx_byte_o), .tx_active_i(tx_active_i),
    .tx_done_i(tx_done_i), .busy_o(busy_o), .err_o(err_o),
    .words_sent_o(words_sent_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] fq[$];
  logic [7:0] wr_log[$];
  logic [7:0] sent_q[$];
  logic [7:0] pop_byte = 8'h00;
  bit         pend = 1'b0;
  bit         outstanding = 1'b0;
  bit         tx_busy = 1'b0;
  int         tx_left = 0;
  bit         force_active = 1'b0;
  bit         drop_dv = 1'b0;
  int         n_pops = 0;
  int         n_txdv = 0;
  int         n_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    wr_log.push_back(b);
  endtask

  function automatic int cnt_of(input int which);
    if (which == 0) return n_pops;
    if (which == 1) return n_txdv;
    return n_done;
  endfunction

  // which: 0 = pops, 1 = tx starts, 2 = completed words
  task automatic wait_for(input int which, input int target, input int limit, input string tag);
    int lim;
    lim = limit;
    while (cnt_of(which) < target && lim > 0) begin
      cyc(1);
      lim--;
    end
    chk(tag, cnt_of(which), target);
  endtask

  // FIFO (one-cycle read latency) and transmitter models, acting on the falling edge
  always @(negedge clk_i) begin
    fifo_rd_dv_i = 1'b0;
    tx_done_i    = 1'b0;
    if (!rstn_i) begin
      pend        = 1'b0;
      outstanding = 1'b0;
      tx_busy     = 1'b0;
      tx_left     = 0;
      n_done      = 0;
    end else begin
      if (pend) begin
        fifo_rd_dv_i   = 1'b1;
        fifo_rd_data_i = pop_byte;
        pend           = 1'b0;
      end
      if (fifo_rd_en_o) begin
        chk("one_in_flight", 32'(outstanding), 32'd0);
        chk("pop_nonempty", 32'(fq.size() != 0), 32'd1);
        if (fq.size() != 0) pop_byte = fq.pop_front();
        pend        = !drop_dv;
        outstanding = 1'b1;
        n_pops++;
      end
      if (tx_busy) begin
        chk("byte_hold", 32'(tx_byte_o), 32'(pop_byte));
        if (tx_left <= 1) begin
          tx_done_i   = 1'b1;
          tx_busy     = 1'b0;
          outstanding = 1'b0;
          n_done++;
        end else begin
          tx_left--;
        end
      end
      if (tx_dv_o) begin
        chk("dv_in_flight", 32'(outstanding && !tx_busy), 32'd1);
        chk("tx_byte", 32'(tx_byte_o), 32'(pop_byte));
        sent_q.push_back(tx_byte_o);
        tx_busy = 1'b1;
        tx_left = $urandom_range(8, 3);
        n_txdv++;
      end
    end
    tx_active_i  = tx_busy || force_active;
    fifo_empty_i = (fq.size() == 0);
    fifo_AE_i    = (fq.size() <= AE_LVL);
  end

  initial begin
    int p0;
    int base;
    int lim;
    rstn_i   = 1'b0;
    enable_i = 1'b0;
    cyc(3);
    chk("rst_ae_level", 32'(AE_level_o), AE_LVL);
    chk("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    chk("rst_tx_dv", 32'(tx_dv_o), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_words", 32'(words_sent_o), 32'd0);
    rstn_i = 1'b1;
    cyc(2);

    // Burst of three words above the AE threshold
    push(8'hBB); push(8'hBC); push(8'hBD);
    enable_i = 1'b1;
    wait_for(2, 3, 300, "t1_done");
    cyc(8);
    chk("t1_words", 32'(words_sent_o), 32'd3);
    chk("t1_pops", n_pops, 3);
    chk("t1_empty", fq.size(), 0);
    chk("t1_idle", 32'(busy_o), 32'd0);
    chk("t1_b0", 32'(sent_q[0]), 32'hBB);
    chk("t1_b1", 32'(sent_q[1]), 32'hBC);
    chk("t1_b2", 32'(sent_q[2]), 32'hBD);
    chk("t1_ae_level", 32'(AE_level_o), AE_LVL);

    // Single residue word waits out the flush interval
    p0 = n_pops;
    push(8'h5A);
    for (int i = 0; i < FLUSH; i++) begin
      cyc(1);
      chk("t2_no_early_pop", 32'(fifo_rd_en_o), 32'd0);
    end
    wait_for(0, p0 + 1, 20, "t2_flush_pop");
    wait_for(2, 4, 100, "t2_done");
    cyc(8);
    chk("t2_byte", 32'(sent_q[sent_q.size()-1]), 32'h5A);
    chk("t2_txdv", n_txdv, 4);
    chk("t2_words", 32'(words_sent_o), 32'd4);

    // Transmitter held busy: strobe withheld, byte stable
    force_active = 1'b1;
    p0 = n_pops;
    push(8'hC1); push(8'hC2); push(8'hC3);
    wait_for(0, p0 + 1, 50, "t3_pop");
    cyc(3);
    for (int i = 0; i < 50; i++) begin
      chk("t3_dv_held", 32'(tx_dv_o), 32'd0);
      chk("t3_byte_stable", 32'(tx_byte_o), 32'hC1);
      cyc(1);
    end
    force_active = 1'b0;
    wait_for(2, 7, 300, "t3_done");
    cyc(8);
    chk("t3_words", 32'(words_sent_o), 32'd7);
    chk("t3_b0", 32'(sent_q[sent_q.size()-3]), 32'hC1);
    chk("t3_b2", 32'(sent_q[sent_q.size()-1]), 32'hC3);

    // Read data never returns: sticky error after the timeout
    drop_dv = 1'b1;
    p0 = n_pops;
    push(8'h11); push(8'h22);
    wait_for(0, p0 + 1, 50, "t4_pop");
    chk("t4_err_early", 32'(err_o), 32'd0);
    chk("t4_busy", 32'(busy_o), 32'd1);
    cyc(DVTO - 1);
    chk("t4_err_not_yet", 32'(err_o), 32'd0);
    cyc(1);
    chk("t4_err_set", 32'(err_o), 32'd1);
    chk("t4_idle", 32'(busy_o), 32'd0);
    enable_i = 1'b0;
    drop_dv  = 1'b0;
    cyc(10);
    chk("t4_err_sticky", 32'(err_o), 32'd1);
    rstn_i = 1'b0;
    cyc(1);
    chk("t4_err_cleared", 32'(err_o), 32'd0);
    chk("t4_words_cleared", 32'(words_sent_o), 32'd0);
    rstn_i = 1'b1;
    cyc(2);

    // Enable dropped mid-word: current word finishes, two stay queued
    p0 = n_pops;
    base = n_txdv;
    push(8'h31); push(8'h32);
    enable_i = 1'b1;
    wait_for(1, base + 1, 50, "t5_txdv");
    enable_i = 1'b0;
    wait_for(2, 1, 50, "t5_done");
    cyc(30);
    chk("t5_one_pop", n_pops - p0, 1);
    chk("t5_left", fq.size(), 2);
    chk("t5_idle", 32'(busy_o), 32'd0);
    chk("t5_byte", 32'(sent_q[sent_q.size()-1]), 32'h22);
    chk("t5_words", 32'(words_sent_o), 32'd1);

    // Reset while holding a word in LOAD, then resume
    force_active = 1'b1;
    p0 = n_pops;
    enable_i = 1'b1;
    wait_for(0, p0 + 1, 50, "t6_pop");
    cyc(2);
    chk("t6_busy_pre", 32'(busy_o), 32'd1);
    chk("t6_dv_pre", 32'(tx_dv_o), 32'd0);
    rstn_i = 1'b0;
    cyc(1);
    chk("t6_tx_dv", 32'(tx_dv_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_words", 32'(words_sent_o), 32'd0);
    chk("t6_tx_byte", 32'(tx_byte_o), 32'd0);
    rstn_i = 1'b1;
    force_active = 1'b0;
    wait_for(2, 1, 200, "t6_resume");
    cyc(8);
    chk("t6_byte", 32'(sent_q[sent_q.size()-1]), 32'h32);
    chk("t6_words_after", 32'(words_sent_o), 32'd1);

    // Random traffic: everything written goes out once, in order
    wr_log.delete();
    sent_q.delete();
    base = n_done;
    for (int r = 0; r < 40; r++) begin
      int k;
      k = $urandom_range(4 - fq.size(), 0);
      for (int j = 0; j < k; j++) push(8'($urandom));
      enable_i = ($urandom_range(3, 0) != 0);
      cyc($urandom_range(30, 1));
    end
    enable_i = 1'b1;
    lim = 1000;
    while (!(fq.size() == 0 && !outstanding && !busy_o) && lim > 0) begin
      cyc(1);
      lim--;
    end
    chk("rnd_drained", 32'(fq.size() == 0 && !outstanding && !busy_o), 32'd1);
    chk("rnd_words", 32'(words_sent_o), 32'(base + wr_log.size()));
    chk("rnd_count", sent_q.size(), wr_log.size());
    for (int i = 0; i < wr_log.size(); i++) begin
      if (i < sent_q.size()) chk("rnd_order", 32'(sent_q[i]), 32'(wr_log[i]));
    end
    chk("rnd_err", 32'(err_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
